regfile_write_arbiter: RTL and testbench



---
 rtl/regfile_write_arbiter.sv | 131 +++++++++++++
 tb/tb_regfile_write_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing one register-file write port between ALU (A) and load unit (B),
// with a bounded burst lock and a one-cycle registered output stage.
module regfile_write_arbiter #(
    parameter int unsigned num_registers  = 32,
    parameter int unsigned register_size  = 32,
    parameter int unsigned max_lock_beats = 4,
    localparam int unsigned AW = $clog2(num_registers),
    localparam int unsigned DW = register_size
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_valid,
    input  logic          a_lock,
    input  logic [AW-1:0] a_rd,
    input  logic [DW-1:0] a_data,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic          b_lock,
    input  logic [AW-1:0] b_rd,
    input  logic [DW-1:0] b_data,
    output logic          b_ready,
    output logic          rf_write_enable,
    output logic [AW-1:0] rf_rd,
    output logic [DW-1:0] rf_write_data,
    output logic          busy
);

    localparam int unsigned CW = $clog2(max_lock_beats + 1);
    localparam logic [CW-1:0] MaxBeats = CW'(max_lock_beats);

    // Side encoding: 0 = A, 1 = B.
    logic          ptr_q, ptr_d;
    logic          lock_act_q, lock_act_d;
    logic          lock_side_q, lock_side_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q;
    logic [AW-1:0] rd_q;
    logic [DW-1:0] data_q;

    logic          any_grant;
    logic          win_b;
    logic          handoff;
    logic          owner_valid;
    logic          other_valid;
    logic          win_lock;
    logic [AW-1:0] win_rd;
    logic [DW-1:0] win_data;
    logic          do_write;

    // Grant decision depends only on valids and arbiter state, never on rd/data/lock.
    always_comb begin
        any_grant   = 1'b0;
        win_b       = 1'b0;
        handoff     = 1'b0;
        owner_valid = lock_side_q ? b_valid : a_valid;
        other_valid = lock_side_q ? a_valid : b_valid;
        if (lock_act_q && owner_valid) begin
            any_grant = 1'b1;
            if (other_valid && (cnt_q >= MaxBeats)) begin
                handoff = 1'b1;
                win_b   = ~lock_side_q;
            end else begin
                win_b   = lock_side_q;
            end
        end else if (a_valid && b_valid) begin
            any_grant = 1'b1;
            win_b     = ptr_q;
        end else if (a_valid) begin
            any_grant = 1'b1;
            win_b     = 1'b0;
        end else if (b_valid) begin
            any_grant = 1'b1;
            win_b     = 1'b1;
        end
    end

    assign a_ready  = any_grant & ~win_b;
    assign b_ready  = any_grant & win_b;
    assign win_lock = win_b ? b_lock : a_lock;
    assign win_rd   = win_b ? b_rd : a_rd;
    assign win_data = win_b ? b_data : a_data;
    assign do_write = any_grant && (win_rd != '0);

    always_comb begin
        ptr_d       = ptr_q;
        lock_act_d  = 1'b0;
        lock_side_d = lock_side_q;
        cnt_d       = '0;
        if (any_grant) begin
            // A forced handoff leaves the pointer on the new winner, away from the old owner.
            ptr_d = handoff ? win_b : ~win_b;
            if (win_lock) begin
                lock_act_d  = 1'b1;
                lock_side_d = win_b;
                if (lock_act_q && (lock_side_q == win_b)) begin
                    cnt_d = (cnt_q < MaxBeats) ? cnt_q + 1'b1 : cnt_q;
                end else begin
                    cnt_d = CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= 1'b0;
            lock_act_q  <= 1'b0;
            lock_side_q <= 1'b0;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            rd_q        <= '0;
            data_q      <= '0;
        end else begin
            ptr_q       <= ptr_d;
            lock_act_q  <= lock_act_d;
            lock_side_q <= lock_side_d;
            cnt_q       <= cnt_d;
            we_q        <= do_write;
            if (do_write) begin
                rd_q   <= win_rd;
                data_q <= win_data;
            end
        end
    end

    assign rf_write_enable = we_q;
    assign rf_rd           = rd_q;
    assign rf_write_data   = data_q;
    assign busy            = we_q | a_valid | b_valid;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: ready/busy checked per cycle, register-file writes
// checked by a queue-driven monitor one cycle after each expected grant.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_valid = 1'b0, a_lock = 1'b0, b_valid = 1'b0, b_lock = 1'b0;
    logic [4:0]  a_rd = '0, b_rd = '0;
    logic [31:0] a_data = '0, b_data = '0;
    logic        a_ready, b_ready, rf_write_enable, busy;
    logic [4:0]  rf_rd;
    logic [31:0] rf_write_data;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic last_wr = 1'b0;

    regfile_write_arbiter #(
        .num_registers (32),
        .register_size (32),
        .max_lock_beats(4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .a_valid        (a_valid),
        .a_lock         (a_lock),
        .a_rd           (a_rd),
        .a_data         (a_data),
        .a_ready        (a_ready),
        .b_valid        (b_valid),
        .b_lock         (b_lock),
        .b_rd           (b_rd),
        .b_data         (b_data),
        .b_ready        (b_ready),
        .rf_write_enable(rf_write_enable),
        .rf_rd          (rf_rd),
        .rf_write_data  (rf_write_data),
        .busy           (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step(input logic av, input logic al, input logic [4:0] ard,
                        input logic [31:0] ad, input logic bv, input logic bl,
                        input logic [4:0] brd, input logic [31:0] bd,
                        input logic ea, input logic eb, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        a_valid = av; a_lock = al; a_rd = ard; a_data = ad;
        b_valid = bv; b_lock = bl; b_rd = brd; b_data = bd;
        @(negedge clk);
        chk({nm, " a_ready"}, a_ready, ea);
        chk({nm, " b_ready"}, b_ready, eb);
        chk({nm, " busy"}, busy, av | bv | last_wr);
        last_wr = 1'b0;
        if (ea && ard != 0) begin
            e.rd = ard; e.data = ad; e.cyc = cyc + 1;
            q.push_back(e);
            last_wr = 1'b1;
        end
        if (eb && brd != 0) begin
            e.rd = brd; e.data = bd; e.cyc = cyc + 1;
            q.push_back(e);
            last_wr = 1'b1;
        end
    endtask

    task automatic idle_inputs();
        a_valid = 1'b0; a_lock = 1'b0; a_rd = '0; a_data = '0;
        b_valid = 1'b0; b_lock = 1'b0; b_rd = '0; b_data = '0;
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #1;
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        last_wr = 1'b0;
    endtask

    // Write monitor: each expected write must appear exactly in its tagged cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            if (!rst) begin
                if (q.size() > 0 && q[0].cyc == cyc) begin
                    e = q.pop_front();
                    chk("wr_en", rf_write_enable, 1'b1);
                    chk("wr_rd", rf_rd, e.rd);
                    chk("wr_data", rf_write_data, e.data);
                end else begin
                    chk("wr_en_idle", rf_write_enable, 1'b0);
                    if (q.size() > 0 && q[0].cyc < cyc) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL missed_write: rd %0d data %0h expected in cycle %0d",
                                 q[0].rd, q[0].data, q[0].cyc);
                        void'(q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset is asynchronous: outputs are cleared before any clock edge.
        #2;
        chk("rst we", rf_write_enable, 1'b0);
        chk("rst rd", rf_rd, 5'd0);
        chk("rst data", rf_write_data, 32'd0);
        chk("rst busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        step(1, 0, 5, 32'hDEADBEEF, 0, 0, 0, 0, 1, 0, "single_a");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "idle");

        reset_dut();
        step(1, 0, 1, 32'h11, 1, 0, 2, 32'h22, 1, 0, "rr0");
        step(1, 0, 1, 32'h11, 1, 0, 2, 32'h22, 0, 1, "rr1");
        step(1, 0, 1, 32'h11, 1, 0, 2, 32'h22, 1, 0, "rr2");
        step(1, 0, 1, 32'h11, 1, 0, 2, 32'h22, 0, 1, "rr3");

        step(1, 0, 0, 32'h1234, 0, 0, 0, 0, 1, 0, "x0_a");
        step(1, 0, 3, 32'h33, 1, 0, 4, 32'h44, 0, 1, "x0_b_next");
        step(1, 0, 3, 32'h33, 0, 0, 0, 0, 1, 0, "x0_a_held");

        step(1, 0, 7, 32'hAAAA, 1, 0, 7, 32'hBBBB, 0, 1, "same_rd_b");
        step(1, 0, 7, 32'hAAAA, 0, 0, 0, 0, 1, 0, "same_rd_a");

        for (int i = 0; i < 4; i++)
            step(1, 0, 8, 32'hA0, 1, 1, 9, 32'hB0 + i, 0, 1, "lock_b");
        step(1, 0, 8, 32'hA0, 1, 1, 9, 32'hB4, 1, 0, "lock_handoff");
        step(1, 0, 8, 32'hA1, 1, 1, 9, 32'hB4, 1, 0, "ptr_after_handoff");
        step(0, 0, 0, 0, 1, 1, 9, 32'hB4, 0, 1, "lock_b_alone");
        for (int i = 0; i < 5; i++)
            step(0, 0, 0, 0, 1, 1, 9, 32'hB5 + i, 0, 1, "lock_persist");
        step(1, 0, 8, 32'hA2, 1, 1, 9, 32'hBA, 1, 0, "persist_handoff");

        step(1, 1, 13, 32'hC0, 0, 0, 0, 0, 1, 0, "a_lock");
        step(1, 0, 13, 32'hC1, 0, 0, 0, 0, 1, 0, "a_unlock");
        step(1, 0, 13, 32'hC2, 1, 0, 14, 32'hD0, 0, 1, "after_unlock");
        step(1, 1, 13, 32'hC3, 0, 0, 0, 0, 1, 0, "a_lock2");
        step(0, 0, 0, 0, 1, 0, 14, 32'hD1, 0, 1, "owner_drop");
        step(1, 0, 13, 32'hC4, 1, 0, 14, 32'hD2, 1, 0, "after_drop");

        // B takes a lock and its write is in flight when reset hits mid-cycle.
        step(0, 0, 0, 0, 1, 1, 10, 32'hCAFE, 0, 1, "pre_reset");
        @(posedge clk);
        #1;
        idle_inputs();
        #3;
        rst = 1'b1;
        #1;
        chk("midrst we", rf_write_enable, 1'b0);
        chk("midrst rd", rf_rd, 5'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        last_wr = 1'b0;
        step(1, 0, 11, 32'h1111, 1, 1, 12, 32'h1212, 1, 0, "post_reset_ptr");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "final_idle");

        @(posedge clk);
        @(posedge clk);
        #4;
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
